// File: rtl/prog_sequencer.sv
// Program sequencer: owns the program counter and the req/ack run handshake,
// selects a program entry point per run, and halts on a halt opcode or a watchdog limit.
module prog_sequencer #(
    parameter int                         PC_W        = 12,
    parameter int                         INST_W      = 9,
    parameter int                         TGT_W       = 8,
    parameter int                         NUM_PROG    = 3,
    parameter int                         SEL_W       = 2,
    parameter logic [NUM_PROG*PC_W-1:0]   ENTRY_PTS   = {12'h100, 12'h080, 12'h000},
    parameter logic [INST_W-1:0]          HALT_CODE   = 9'h1FF,
    parameter int                         BRANCH_MODE = 0,
    parameter int                         MAX_CYCLES  = 4096
) (
    input  logic                          clk,
    input  logic                          init,
    input  logic                          req,
    input  logic [SEL_W-1:0]              prog_sel,
    input  logic [INST_W-1:0]             inst,
    input  logic                          branch_en,
    input  logic                          branch_taken,
    input  logic [TGT_W-1:0]              branch_target,
    output logic [PC_W-1:0]               pc,
    output logic                          run,
    output logic                          ack,
    output logic                          timeout,
    output logic [$clog2(MAX_CYCLES):0]   cyc_count
);

    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    generate
        if (NUM_PROG < 1 || MAX_CYCLES < 2 || (1 << SEL_W) < NUM_PROG) begin : g_bad_params
            $error("prog_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [SEL_W-1:0]   sel_q, sel_nx;
    logic [PC_W-1:0]    pc_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               timeout_nx;
    logic [PC_W-1:0]    entry;
    logic [PC_W-1:0]    jump_pc;
    logic signed [TGT_W-1:0] tgt_s;

    // Out-of-range selects fall back to entry 0.
    always_comb begin
        entry = ENTRY_PTS[PC_W-1:0];
        for (int i = 1; i < NUM_PROG; i++) begin
            if (sel_q == SEL_W'(i)) entry = ENTRY_PTS[i*PC_W +: PC_W];
        end
    end

    // A size cast of a signed operand sign-extends; pc arithmetic wraps modulo 2^PC_W.
    assign tgt_s = branch_target;
    always_comb begin
        if (BRANCH_MODE == 1) jump_pc = pc + PC_W'(tgt_s);
        else                  jump_pc = PC_W'(branch_target);
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        sel_nx     = sel_q;
        pc_nx      = pc;
        cnt_nx     = cyc_count;
        timeout_nx = timeout;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = LOAD;
                    sel_nx   = prog_sel;
                end
            end
            LOAD: begin
                pc_nx      = entry;
                cnt_nx     = '0;
                timeout_nx = 1'b0;
                state_nx   = RUN;
            end
            RUN: begin
                if (inst == HALT_CODE) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cyc_count + CNT_W'(1);
                    if (cyc_count == LAST_CYC) begin
                        state_nx   = DONE;
                        timeout_nx = 1'b1;
                    end else if (branch_en && branch_taken) begin
                        pc_nx = jump_pc;
                    end else begin
                        pc_nx = pc + PC_W'(1);
                    end
                end
            end
            DONE: begin
                if (!req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state     <= IDLE;
            sel_q     <= '0;
            pc        <= '0;
            cyc_count <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            sel_q     <= sel_nx;
            pc        <= pc_nx;
            cyc_count <= cnt_nx;
            timeout   <= timeout_nx;
        end
    end

    assign run = (state == RUN);
    assign ack = (state == DONE);

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: an absolute-branch instance with defaults and a
// PC-relative instance with a 16-instruction watchdog and a 0xFFF entry point.
module tb_prog_sequencer;

    localparam int NI = 2;
    localparam logic [8:0] HALT = 9'h1FF;
    localparam logic [8:0] NOP  = 9'h000;

    typedef struct { logic [8:0] op; logic en; logic tk; logic [7:0] tg; } rom_t;
    typedef struct { logic [11:0] pc; logic [12:0] cnt; } step_t;
    typedef struct { int lat; logic [12:0] cnt; logic tmo; logic chk_pc; logic [11:0] pc; } done_t;

    logic clk = 1'b0;
    logic init = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]        req;
    logic [NI-1:0][1:0]   sel;
    logic [NI-1:0][8:0]   inst;
    logic [NI-1:0]        br_en, br_tk;
    logic [NI-1:0][7:0]   br_tg;
    wire  [NI-1:0][11:0]  pc;
    wire  [NI-1:0]        run, ack, tmo;
    wire  [12:0]          cnt_a;
    wire  [4:0]           cnt_b;
    wire  [NI-1:0][12:0]  cnt;
    assign cnt = {13'(cnt_b), cnt_a};

    rom_t  rom [NI][4096];
    step_t step_q[$];
    done_t done_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            inst[i]  = rom[i][pc[i]].op;
            br_en[i] = rom[i][pc[i]].en;
            br_tk[i] = rom[i][pc[i]].tk;
            br_tg[i] = rom[i][pc[i]].tg;
        end
    end

    prog_sequencer u_abs (
        .clk(clk), .init(init), .req(req[0]), .prog_sel(sel[0]), .inst(inst[0]),
        .branch_en(br_en[0]), .branch_taken(br_tk[0]), .branch_target(br_tg[0]),
        .pc(pc[0]), .run(run[0]), .ack(ack[0]), .timeout(tmo[0]), .cyc_count(cnt_a)
    );

    prog_sequencer #(
        .BRANCH_MODE(1), .MAX_CYCLES(16), .ENTRY_PTS({12'h100, 12'h080, 12'hFFF})
    ) u_rel (
        .clk(clk), .init(init), .req(req[1]), .prog_sel(sel[1]), .inst(inst[1]),
        .branch_en(br_en[1]), .branch_taken(br_tk[1]), .branch_target(br_tg[1]),
        .pc(pc[1]), .run(run[1]), .ack(ack[1]), .timeout(tmo[1]), .cyc_count(cnt_b)
    );

    task automatic clear_rom(input int d);
        for (int a = 0; a < 4096; a++) rom[d][a] = '{NOP, 1'b0, 1'b0, 8'h00};
    endtask

    task automatic put(input int d, input int a, input logic [8:0] op,
                       input logic en, input logic tk, input logic [7:0] tg);
        rom[d][a] = '{op, en, tk, tg};
    endtask

    function automatic logic [11:0] entry_of(input int d, input logic [1:0] s);
        case (s)
            2'd1:    return 12'h080;
            2'd2:    return 12'h100;
            default: return (d == 0) ? 12'h000 : 12'hFFF;
        endcase
    endfunction

    // Called at a falling edge: predicts the run, raises req, then scores every RUN cycle and the end.
    task automatic do_run(input int d, input logic [1:0] s);
        logic [11:0] p;
        int n, steps, edges, maxc;
        logic to;
        done_t dn;
        step_t e;
        maxc = (d == 0) ? 4096 : 16;
        p = entry_of(d, s);
        n = 0; steps = 0; to = 1'b0;
        forever begin
            step_q.push_back('{p, 13'(n)});
            steps++;
            if (rom[d][p].op == HALT) break;
            n++;
            if (n == maxc) begin to = 1'b1; break; end
            if (rom[d][p].en && rom[d][p].tk)
                p = (d == 1) ? p + {{4{rom[d][p].tg[7]}}, rom[d][p].tg} : {4'h0, rom[d][p].tg};
            else
                p = p + 12'd1;
        end
        done_q.push_back('{steps + 2, 13'(n), to, !to, p});

        sel[d] = s;
        req[d] = 1'b1;
        edges = 0;
        while (edges < maxc + 10) begin
            @(posedge clk); #1;
            edges++;
            if (run[d] === 1'b1) begin
                n_cmp++;
                if (step_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL run_extra d=%0d pc=%h: run high with no instruction expected", d, pc[d]);
                end else begin
                    e = step_q.pop_front();
                    if (pc[d] !== e.pc || cnt[d] !== e.cnt || tmo[d] !== 1'b0 || ack[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL run_step d=%0d got pc=%h cnt=%0d tmo=%b ack=%b want pc=%h cnt=%0d tmo=0 ack=0",
                                 d, pc[d], cnt[d], tmo[d], ack[d], e.pc, e.cnt);
                    end
                end
            end
            if (ack[d] === 1'b1) break;
        end
        dn = done_q.pop_front();
        n_cmp++;
        if (ack[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_wait d=%0d got ack=%b after %0d edges want ack=1 after %0d", d, ack[d], edges, dn.lat);
        end else if (edges != dn.lat || cnt[d] !== dn.cnt || tmo[d] !== dn.tmo || run[d] !== 1'b0 ||
                     (dn.chk_pc && pc[d] !== dn.pc) || step_q.size() != 0) begin
            n_bad++;
            $display("FAIL run_end d=%0d got lat=%0d cnt=%0d tmo=%b pc=%h run=%b left=%0d want lat=%0d cnt=%0d tmo=%b pc=%h run=0 left=0",
                     d, edges, cnt[d], tmo[d], pc[d], run[d], step_q.size(), dn.lat, dn.cnt, dn.tmo, dn.pc);
        end
        step_q.delete();
    endtask

    task automatic release_req(input int d, input logic exp_tmo);
        @(negedge clk);
        req[d] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ack[d] !== 1'b0 || run[d] !== 1'b0 || tmo[d] !== exp_tmo) begin
            n_bad++;
            $display("FAIL release d=%0d got ack=%b run=%b tmo=%b want ack=0 run=0 tmo=%b",
                     d, ack[d], run[d], tmo[d], exp_tmo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        req = '0;
        sel = '0;
        init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) begin
            n_cmp++;
            if (pc[d] !== 12'h000 || run[d] !== 1'b0 || ack[d] !== 1'b0 || tmo[d] !== 1'b0 || cnt[d] !== 13'd0) begin
                n_bad++;
                $display("FAIL reset d=%0d got pc=%h run=%b ack=%b tmo=%b cnt=%0d want all zero",
                         d, pc[d], run[d], ack[d], tmo[d], cnt[d]);
            end
        end
        @(negedge clk);
        init = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (run[0] !== 1'b0 || ack[0] !== 1'b0 || pc[0] !== 12'h000) begin
            n_bad++;
            $display("FAIL idle_hold got run=%b ack=%b pc=%h want 0 0 000", run[0], ack[0], pc[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_sequential;
        clear_rom(0);
        put(0, 'h085, HALT, 1'b0, 1'b0, 8'h00);
        do_run(0, 2'd1);
        release_req(0, 1'b0);
    endtask

    task automatic test_abs_branch;
        clear_rom(0);
        put(0, 'h080, NOP,  1'b1, 1'b0, 8'h55);
        put(0, 'h081, NOP,  1'b1, 1'b1, 8'h20);
        put(0, 'h020, HALT, 1'b0, 1'b0, 8'h00);
        do_run(0, 2'd1);
        release_req(0, 1'b0);
    endtask

    task automatic test_rel_branch;
        clear_rom(1);
        put(1, 'h102, NOP,  1'b1, 1'b1, 8'hFC);
        put(1, 'h0FE, HALT, 1'b0, 1'b0, 8'h00);
        do_run(1, 2'd2);
        release_req(1, 1'b0);
        clear_rom(1);
        put(1, 'h102, NOP,  1'b1, 1'b0, 8'hFC);
        put(1, 'h103, HALT, 1'b0, 1'b0, 8'h00);
        do_run(1, 2'd2);
        release_req(1, 1'b0);
    endtask

    task automatic test_watchdog;
        clear_rom(1);
        do_run(1, 2'd1);
        release_req(1, 1'b1);
        put(1, 'h08F, HALT, 1'b0, 1'b0, 8'h00);
        do_run(1, 2'd1);
        release_req(1, 1'b0);
    endtask

    task automatic test_wrap;
        clear_rom(1);
        put(1, 'h000, NOP,  1'b1, 1'b1, 8'h20);
        put(1, 'h020, HALT, 1'b0, 1'b0, 8'h00);
        do_run(1, 2'd0);
        release_req(1, 1'b0);
    endtask

    task automatic test_init_midrun;
        clear_rom(0);
        put(0, 'h08A, HALT, 1'b0, 1'b0, 8'h00);
        sel[0] = 2'd1;
        req[0] = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (run[0] !== 1'b1 || pc[0] !== 12'h082) begin
            n_bad++;
            $display("FAIL pre_init got run=%b pc=%h want run=1 pc=082", run[0], pc[0]);
        end
        init = 1'b1;
        #1;
        n_cmp++;
        if (pc[0] !== 12'h000 || run[0] !== 1'b0 || ack[0] !== 1'b0 || cnt[0] !== 13'd0) begin
            n_bad++;
            $display("FAIL async_init got pc=%h run=%b ack=%b cnt=%0d want 000 0 0 0", pc[0], run[0], ack[0], cnt[0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (pc[0] !== 12'h000 || run[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL init_held got pc=%h run=%b want 000 0", pc[0], run[0]);
        end
        @(negedge clk);
        init = 1'b0;
        do_run(0, 2'd1);
        release_req(0, 1'b0);
    endtask

    task automatic test_done_hold;
        clear_rom(0);
        put(0, 'h082, HALT, 1'b0, 1'b0, 8'h00);
        put(0, 'h003, HALT, 1'b0, 1'b0, 8'h00);
        do_run(0, 2'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ack[0] !== 1'b1 || run[0] !== 1'b0 || pc[0] !== 12'h082 || cnt[0] !== 13'd2) begin
                n_bad++;
                $display("FAIL done_hold k=%0d got ack=%b run=%b pc=%h cnt=%0d want 1 0 082 2",
                         k, ack[0], run[0], pc[0], cnt[0]);
            end
        end
        @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ack[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_drop got ack=%b want 0", ack[0]);
        end
        @(negedge clk);
        do_run(0, 2'd3);
        release_req(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_abs_branch();
        test_rel_branch();
        test_watchdog();
        test_wrap();
        test_init_midrun();
        test_done_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached before the summary");
        $fatal(1, "time limit");
    end

endmodule
